// File: rtl/uart_chip_emu_if.sv
// Parallel strobe bus between the CPU-side UART controller (master) and the
// soft UART device (slave); mirrors the external UART chip's pinout.
interface uart_chip_emu_if;
    logic       wrn;
    logic       rdn;
    logic [7:0] uart_din;
    logic [7:0] uart_dout;
    logic       uart_doe;
    logic       data_ready;
    logic       tbre;
    logic       tsre;

    modport master (
        output wrn, rdn, uart_din,
        input  uart_dout, uart_doe, data_ready, tbre, tsre
    );

    modport slave (
        input  wrn, rdn, uart_din,
        output uart_dout, uart_doe, data_ready, tbre, tsre
    );
endinterface

// File: rtl/uart_chip_emu.sv
// Soft 8N1 UART answering the external UART chip's rdn/wrn strobe protocol.
// Define UART_LOOPBACK_EN to feed the TX bit into RX internally (txd held high).
module uart_chip_emu #(
    parameter int CLKS_PER_BIT = 96
) (
    input  logic            clk,
    input  logic            rst,
    uart_chip_emu_if.slave  bus,
    output logic            rx_overrun,
    output logic            frame_err,
    input  logic            rxd,
    output logic            txd
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t        tx_state;
    rx_state_t        rx_state;
    logic             wrn_q, rdn_q, wr_edge, rd_end, tx_load;
    logic [7:0]       thr, tx_shift, rbr, rx_shift;
    logic             tbre, tsre, data_ready, tx_bit;
    logic [CNT_W-1:0] tx_cnt, rx_cnt;
    logic [3:0]       tx_idx, rx_idx;
    logic             rx_src, rx_meta, rxs;

    assign wr_edge = wrn_q & ~bus.wrn;
    assign rd_end  = ~rdn_q & bus.rdn;

    assign bus.uart_doe   = ~bus.rdn & ~rst;
    assign bus.uart_dout  = rbr;
    assign bus.data_ready = data_ready;
    assign bus.tbre       = tbre;
    assign bus.tsre       = tsre;

`ifdef UART_LOOPBACK_EN
    logic unused_rxd;
    assign unused_rxd = rxd;
    assign rx_src     = tx_bit;
    assign txd        = 1'b1;
`else
    assign rx_src = rxd;
    assign txd    = tx_bit;
`endif

    // Reloading on the last stop cycle gives gap-free back-to-back frames
    assign tx_load = ~tbre & ((tx_state == TX_IDLE) ||
                              (tx_state == TX_STOP && tx_cnt == BIT_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            wrn_q    <= 1'b1;
            thr      <= '0;
            tx_shift <= '0;
            tbre     <= 1'b1;
            tsre     <= 1'b1;
            tx_bit   <= 1'b1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_state <= TX_IDLE;
        end else begin
            wrn_q <= bus.wrn;
            if (wr_edge && tbre) begin
                thr  <= bus.uart_din;
                tbre <= 1'b0;
            end
            if (tx_load) begin
                tx_shift <= thr;
                tbre     <= 1'b1;
                tsre     <= 1'b0;
                tx_bit   <= 1'b0;
                tx_cnt   <= '0;
                tx_state <= TX_START;
            end else if (tx_state != TX_IDLE) begin
                if (tx_cnt != BIT_LAST) begin
                    tx_cnt <= tx_cnt + 1'b1;
                end else begin
                    tx_cnt <= '0;
                    case (tx_state)
                        TX_START: begin
                            tx_idx   <= '0;
                            tx_bit   <= tx_shift[0];
                            tx_state <= TX_DATA;
                        end
                        TX_DATA: begin
                            if (tx_idx == 4'd7) begin
                                tx_bit   <= 1'b1;
                                tx_state <= TX_STOP;
                            end else begin
                                tx_idx   <= tx_idx + 1'b1;
                                tx_shift <= tx_shift >> 1;
                                tx_bit   <= tx_shift[1];
                            end
                        end
                        default: begin
                            tsre     <= 1'b1;
                            tx_state <= TX_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // Synchronizer resets high so reset release never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rdn_q      <= 1'b1;
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            rx_shift   <= '0;
            rbr        <= '0;
            data_ready <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_state   <= RX_IDLE;
        end else begin
            rdn_q     <= bus.rdn;
            rx_meta   <= rx_src;
            rxs       <= rx_meta;
            frame_err <= 1'b0;
            if (rd_end) begin
                data_ready <= 1'b0;
                rx_overrun <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rxs) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxs, rx_shift[7:1]};
                        if (rx_idx == 4'd7) rx_state <= RX_STOP;
                        else                rx_idx   <= rx_idx + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rxs) begin
                            rbr        <= rx_shift;
                            data_ready <= 1'b1;
                            if (data_ready && !rd_end) rx_overrun <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_chip_emu.sv
// Directed bench for uart_chip_emu at CLKS_PER_BIT=4: strobe bus, TX framing,
// RX receive/overrun/framing/glitch handling, reset abort, optional loopback.
module tb_uart_chip_emu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic txd, rx_overrun, frame_err;
    int   total = 0;
    int   bad   = 0;
    int   fe_count = 0;

    uart_chip_emu_if bus();

    uart_chip_emu #(.CLKS_PER_BIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rx_overrun (rx_overrun),
        .frame_err  (frame_err),
        .rxd        (rxd),
        .txd        (txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err) fe_count <= fe_count + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic send_rx(input logic [7:0] b, input logic stop);
        for (int i = 0; i < 10; i++) begin
            rxd = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
            repeat (4) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.rdn = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b exp=1", txd); end
        total++; if (bus.tbre !== 1'b1) begin bad++; $display("FAIL reset_tbre got=%b exp=1", bus.tbre); end
        total++; if (bus.tsre !== 1'b1) begin bad++; $display("FAIL reset_tsre got=%b exp=1", bus.tsre); end
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL reset_dr got=%b exp=0", bus.data_ready); end
        total++; if (bus.uart_doe !== 1'b0) begin bad++; $display("FAIL reset_doe got=%b exp=0", bus.uart_doe); end
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", rx_overrun); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b exp=0", frame_err); end
        total++; if (bus.uart_dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", bus.uart_dout); end
        bus.rdn = 1'b1; rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tx;
        logic [9:0] fa5;
        fa5 = 10'b1101001010;
        bus.wrn = 1'b0; bus.uart_din = 8'hA5;
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.wrn = 1'b1;
                total++; if (bus.tbre !== 1'b0) begin bad++; $display("FAIL tx_tbre_w1 got=%b exp=0", bus.tbre); end
                total++; if (txd !== 1'b1) begin bad++; $display("FAIL tx_idle_w1 got=%b exp=1", txd); end
            end
            if (k == 2) begin
                total++; if (bus.tbre !== 1'b1) begin bad++; $display("FAIL tx_tbre_w2 got=%b exp=1", bus.tbre); end
            end
            if (k >= 2 && k <= 41) begin
                total++;
                if (txd !== fa5[(k-2)/4]) begin bad++; $display("FAIL tx_a5_bit cyc=W+%0d got=%b exp=%b", k, txd, fa5[(k-2)/4]); end
                total++;
                if (bus.tsre !== 1'b0) begin bad++; $display("FAIL tx_tsre_busy cyc=W+%0d got=%b exp=0", k, bus.tsre); end
            end
            if (k >= 42) begin
                total++; if (bus.tsre !== 1'b1) begin bad++; $display("FAIL tx_tsre_done cyc=W+%0d got=%b exp=1", k, bus.tsre); end
                total++; if (txd !== 1'b1) begin bad++; $display("FAIL tx_idle_after cyc=W+%0d got=%b exp=1", k, txd); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic expb;
        int   idx;
        bus.wrn = 1'b0; bus.uart_din = 8'h12;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            idx = (k - 2) / 4;
            if (k >= 2 && k <= 81) expb = (idx < 10) ? frame_bit(8'h12, idx) : frame_bit(8'h34, idx - 10);
            else expb = 1'b1;
            total++; if (txd !== expb) begin bad++; $display("FAIL b2b_txd cyc=W+%0d got=%b exp=%b", k, txd, expb); end
            if (k == 3) begin
                total++; if (bus.tbre !== 1'b0) begin bad++; $display("FAIL b2b_tbre_held got=%b exp=0", bus.tbre); end
            end
            if (k == 42) begin
                total++; if (bus.tbre !== 1'b1) begin bad++; $display("FAIL b2b_tbre_reload got=%b exp=1", bus.tbre); end
                total++; if (bus.tsre !== 1'b0) begin bad++; $display("FAIL b2b_tsre_reload got=%b exp=0", bus.tsre); end
            end
            if (k == 82) begin
                total++; if (bus.tsre !== 1'b1) begin bad++; $display("FAIL b2b_tsre_end got=%b exp=1", bus.tsre); end
            end
            case (k)
                1: bus.wrn = 1'b1;
                2: begin bus.wrn = 1'b0; bus.uart_din = 8'h34; end
                3: bus.wrn = 1'b1;
                6: begin bus.wrn = 1'b0; bus.uart_din = 8'h56; end
                7: bus.wrn = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_midframe;
        bus.wrn = 1'b0; bus.uart_din = 8'h00;
        @(negedge clk); bus.wrn = 1'b1;
        repeat (9) @(negedge clk);
        total++; if (txd !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", txd); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL rstmid_txd got=%b exp=1", txd); end
        total++; if (bus.tsre !== 1'b1) begin bad++; $display("FAIL rstmid_tsre got=%b exp=1", bus.tsre); end
        total++; if (bus.tbre !== 1'b1) begin bad++; $display("FAIL rstmid_tbre got=%b exp=1", bus.tbre); end
        repeat (45) @(negedge clk);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL rstmid_stays_idle got=%b exp=1", txd); end
    endtask

    task automatic test_rx_read;
        send_rx(8'h3C, 1'b1);
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL rx_dr_early got=%b exp=0", bus.data_ready); end
        @(negedge clk);
        total++; if (bus.data_ready !== 1'b1) begin bad++; $display("FAIL rx_dr got=%b exp=1", bus.data_ready); end
        bus.rdn = 1'b0;
        #1;
        total++; if (bus.uart_doe !== 1'b1) begin bad++; $display("FAIL rx_doe got=%b exp=1", bus.uart_doe); end
        total++; if (bus.uart_dout !== 8'h3C) begin bad++; $display("FAIL rx_dout got=%h exp=3c", bus.uart_dout); end
        repeat (4) @(negedge clk);
        total++; if (bus.data_ready !== 1'b1) begin bad++; $display("FAIL rx_dr_during_rd got=%b exp=1", bus.data_ready); end
        bus.rdn = 1'b1;
        #1;
        total++; if (bus.uart_doe !== 1'b0) begin bad++; $display("FAIL rx_doe_off got=%b exp=0", bus.uart_doe); end
        total++; if (bus.data_ready !== 1'b1) begin bad++; $display("FAIL rx_dr_hold got=%b exp=1", bus.data_ready); end
        @(negedge clk);
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL rx_dr_clear got=%b exp=0", bus.data_ready); end
    endtask

    task automatic test_rx_overrun;
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        @(negedge clk);
        total++; if (rx_overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", rx_overrun); end
        total++; if (bus.data_ready !== 1'b1) begin bad++; $display("FAIL ovr_dr got=%b exp=1", bus.data_ready); end
        total++; if (bus.uart_dout !== 8'h22) begin bad++; $display("FAIL ovr_dout got=%h exp=22", bus.uart_dout); end
        bus.rdn = 1'b0; @(negedge clk);
        bus.rdn = 1'b1; @(negedge clk);
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", rx_overrun); end
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL ovr_dr_clear got=%b exp=0", bus.data_ready); end
    endtask

    task automatic test_frame_err;
        int fe0;
        fe0 = fe_count;
        send_rx(8'h77, 1'b0);
        repeat (12) @(negedge clk);
        total++; if (fe_count - fe0 !== 1) begin bad++; $display("FAIL fe_pulses got=%0d exp=1", fe_count - fe0); end
        total++; if (bus.uart_dout !== 8'h22) begin bad++; $display("FAIL fe_rbr got=%h exp=22", bus.uart_dout); end
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL fe_dr got=%b exp=0", bus.data_ready); end
    endtask

    task automatic test_glitch;
        int fe0;
        fe0 = fe_count;
        rxd = 1'b0; @(negedge clk); rxd = 1'b1;
        repeat (50) @(negedge clk);
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL glitch_dr got=%b exp=0", bus.data_ready); end
        total++; if (bus.uart_dout !== 8'h22) begin bad++; $display("FAIL glitch_rbr got=%h exp=22", bus.uart_dout); end
        total++; if (fe_count !== fe0) begin bad++; $display("FAIL glitch_fe got=%0d exp=%0d", fe_count, fe0); end
    endtask

    task automatic test_loopback;
        bit got;
        got = 1'b0;
        bus.wrn = 1'b0; bus.uart_din = 8'h5A;
        for (int k = 1; k <= 80 && !got; k++) begin
            @(negedge clk);
            bus.wrn = 1'b1;
            total++; if (txd !== 1'b1) begin bad++; $display("FAIL lb_txd cyc=%0d got=%b exp=1", k, txd); end
            if (bus.data_ready === 1'b1) got = 1'b1;
        end
        total++; if (!got) begin bad++; $display("FAIL lb_timeout got=no_byte exp=data_ready"); end
        total++; if (bus.uart_dout !== 8'h5A) begin bad++; $display("FAIL lb_rbr got=%h exp=5a", bus.uart_dout); end
    endtask

    initial begin
        bus.wrn = 1'b1; bus.rdn = 1'b1; bus.uart_din = 8'h00;
        @(negedge clk);
        test_reset();
`ifdef UART_LOOPBACK_EN
        test_loopback();
`else
        test_tx();
        test_back_to_back();
        test_reset_midframe();
        test_rx_read();
        test_rx_overrun();
        test_frame_err();
        test_glitch();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
